// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the PC, instruction-memory and decoder signals of
// the fetch sequencer into one bundle.
//   master : the fetch sequencer side (drives PC control, memory request,
//            queue head and branch acknowledge)
//   slave  : the surroundings (PC, instruction memory, decoder)
// Signals:
//   pc_bus_in/pc_bus_out/pc_ctl/step_pc  PC control and system bus
//   mem_req/mem_addr/mem_rdata/mem_ack   instruction memory read
//   instr_valid/instr_ready/instr_data/instr_addr  queue head to decoder
//   branch_req/branch_offset/branch_ack  decoder branch request
//   fetch_err                            sticky fetch timeout flag
interface fetch_sequencer_if;
  logic [31:0] pc_bus_in;
  logic [31:0] pc_bus_out;
  logic [1:0]  pc_ctl;
  logic        step_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        branch_req;
  logic [31:0] branch_offset;
  logic        branch_ack;
  logic        fetch_err;

  modport master (
    input  pc_bus_in, mem_rdata, mem_ack, instr_ready, branch_req, branch_offset,
    output pc_bus_out, pc_ctl, step_pc, mem_req, mem_addr, instr_valid,
           instr_data, instr_addr, branch_ack, fetch_err
  );

  modport slave (
    output pc_bus_in, mem_rdata, mem_ack, instr_ready, branch_req, branch_offset,
    input  pc_bus_out, pc_ctl, step_pc, mem_req, mem_addr, instr_valid,
           instr_data, instr_addr, branch_ack, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: controls the PC, fetches instruction words from memory and
// queues them in order for the decoder.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  fetch_sequencer_if.master (PC bus/ctl/step, memory read, queue head,
//        branch handshake, fetch_err)
// Parameters:
//   DEPTH           queue entries (power of two, >= 2)
//   TIMEOUT_CYCLES  REQ wait limit, used only when FETCH_TIMEOUT_EN is defined
// Build option:
//   FETCH_TIMEOUT_EN  abandon a fetch after TIMEOUT_CYCLES REQ cycles without
//                     mem_ack and raise the sticky fetch_err; otherwise REQ
//                     waits forever and fetch_err is tied low.
module fetch_sequencer #(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, REQ, ST_SETUP, ST_PULSE, BR_SETUP, BR_PULSE
  } state_t;

  state_t      state_q;
  logic [1:0]  pc_ctl_q;
  logic        step_q, mem_req_q, br_ack_q, err_q;
  logic [31:0] mem_addr_q, pc_bus_out_q;

  // queue storage and pointers
  logic [31:0] q_data_q [DEPTH];
  logic [31:0] q_addr_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [31:0] hd_data_q, hd_data_d, hd_addr_q, hd_addr_d;
  logic        push, pop, flush;

  // fetched data is dropped when a branch is pending at completion
  assign push  = (state_q == REQ) && bus.mem_ack && !bus.branch_req;
  assign pop   = vld_q && bus.instr_ready;
  assign flush = (state_q == BR_SETUP);

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    hd_data_d = hd_data_q;
    hd_addr_d = hd_addr_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      // registered head: the next head slot may be the one being written now
      if (push && (wr_q == rd_d)) begin
        hd_data_d = bus.mem_rdata;
        hd_addr_d = mem_addr_q;
      end else begin
        hd_data_d = q_data_q[rd_d];
        hd_addr_d = q_addr_q[rd_d];
      end
    end
    vld_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wr_q] <= bus.mem_rdata;
      q_addr_q[wr_q] <= mem_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      hd_data_q <= '0;
      hd_addr_q <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      hd_data_q <= hd_data_d;
      hd_addr_q <= hd_addr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Control FSM. Every output is set on the transition into the state that
  // shows it, so ctl/bus settle a full cycle before step_pc rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_ctl_q     <= 2'b00;
      step_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pc_bus_out_q <= '0;
      br_ack_q     <= 1'b0;
      err_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.branch_req) begin
            state_q      <= BR_SETUP;
            pc_bus_out_q <= bus.branch_offset;
            pc_ctl_q     <= 2'b01;
          end else if (cnt_q != CW'(DEPTH)) begin
            state_q  <= ADDR;
            pc_ctl_q <= 2'b10;
          end
        end
        ADDR: begin
          mem_addr_q <= bus.pc_bus_in;
          mem_req_q  <= 1'b1;
          pc_ctl_q   <= 2'b00;
          state_q    <= REQ;
`ifdef FETCH_TIMEOUT_EN
          to_cnt_q   <= '0;
`endif
        end
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (bus.branch_req) begin
              state_q      <= BR_SETUP;
              pc_bus_out_q <= bus.branch_offset;
              pc_ctl_q     <= 2'b01;
            end else begin
              state_q <= ST_SETUP;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ST_SETUP: begin
          step_q  <= 1'b1;
          state_q <= ST_PULSE;
        end
        ST_PULSE: begin
          step_q  <= 1'b0;
          state_q <= IDLE;
        end
        BR_SETUP: begin
          step_q   <= 1'b1;
          br_ack_q <= 1'b1;
          state_q  <= BR_PULSE;
        end
        BR_PULSE: begin
          step_q       <= 1'b0;
          br_ack_q     <= 1'b0;
          pc_ctl_q     <= 2'b00;
          pc_bus_out_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc_ctl      = pc_ctl_q;
  assign bus.step_pc     = step_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.pc_bus_out  = pc_bus_out_q;
  assign bus.branch_ack  = br_ack_q;
  assign bus.instr_valid = vld_q;
  assign bus.instr_data  = hd_data_q;
  assign bus.instr_addr  = hd_addr_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err   = err_q;
`else
  assign bus.fetch_err   = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();
  fetch_sequencer #(.DEPTH(2), .TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec = 0;
  int errs = 0;
  logic [31:0] pc_model = 32'h0;
  int step_cnt = 0;
  logic [1:0] last_ctl = 2'b00;
  bit ack_en = 1'b1;
  int ack_delay = 0;
  int rsp_wc = 0;

  assign bus.pc_bus_in = pc_model;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  // memory responder: one-cycle ack after ack_delay REQ cycles
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      else if (bus.mem_req && ack_en && !rst) begin
        if (rsp_wc == ack_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = word_of(bus.mem_addr);
          rsp_wc = 0;
        end else rsp_wc++;
      end else rsp_wc = 0;
    end
  end

  // PC model: acts on the rising edge of step_pc
  initial forever begin
    @(posedge bus.step_pc);
    step_cnt++;
    last_ctl = bus.pc_ctl;
    if (bus.pc_ctl[0]) pc_model = pc_model + bus.pc_bus_out;
    else pc_model = pc_model + 32'd4;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [31:0] pc0);
    @(negedge clk);
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.branch_req = 1'b0;
    bus.branch_offset = '0;
    ack_en = 1'b1;
    ack_delay = 0;
    pc_model = pc0;
    step_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'h0);
    rst = 1'b1;
    #1;
    vec++; if ({bus.pc_ctl, bus.step_pc, bus.mem_req, bus.branch_ack, bus.fetch_err, bus.instr_valid} !== 7'b0) begin
      errs++; $display("FAIL reset_ctrl got %b want 0", {bus.pc_ctl, bus.step_pc, bus.mem_req, bus.branch_ack, bus.fetch_err, bus.instr_valid}); end
    vec++; if (bus.mem_addr !== 32'h0) begin errs++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    vec++; if (bus.pc_bus_out !== 32'h0) begin errs++; $display("FAIL reset_pc_bus_out got %h want 0", bus.pc_bus_out); end
  endtask

  task automatic test_fetch();
    do_reset(32'h100);
    @(negedge clk);
    vec++; if (bus.pc_ctl !== 2'b10) begin errs++; $display("FAIL fetch_addr_ctl got %b want 10", bus.pc_ctl); end
    @(negedge clk);
    vec++; if (bus.mem_addr !== 32'h100 || bus.mem_req !== 1'b1 || bus.pc_ctl !== 2'b00) begin
      errs++; $display("FAIL fetch_req got addr=%h req=%b ctl=%b want 100/1/00", bus.mem_addr, bus.mem_req, bus.pc_ctl); end
    @(negedge clk);
    vec++; if (bus.instr_valid !== 1'b1 || bus.instr_data !== 32'hDEADBEEF || bus.instr_addr !== 32'h100 || bus.mem_req !== 1'b0) begin
      errs++; $display("FAIL fetch_push got v=%b d=%h a=%h req=%b want 1/deadbeef/100/0", bus.instr_valid, bus.instr_data, bus.instr_addr, bus.mem_req); end
    @(negedge clk);
    vec++; if (bus.step_pc !== 1'b1 || bus.pc_ctl !== 2'b00) begin
      errs++; $display("FAIL fetch_step got step=%b ctl=%b want 1/00", bus.step_pc, bus.pc_ctl); end
    @(negedge clk);
    vec++; if (bus.step_pc !== 1'b0 || step_cnt != 1 || pc_model !== 32'h104) begin
      errs++; $display("FAIL fetch_after got step=%b n=%0d pc=%h want 0/1/104", bus.step_pc, step_cnt, pc_model); end
  endtask

  task automatic test_queue_full();
    bit seen = 1'b0;
    int n = 0;
    repeat (12) @(negedge clk);
    vec++; if (step_cnt != 2 || pc_model !== 32'h108) begin
      errs++; $display("FAIL full_steps got n=%0d pc=%h want 2/108", step_cnt, pc_model); end
    repeat (8) begin @(negedge clk); if (bus.mem_req) seen = 1'b1; end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL full_no_req got req_seen=%b want 0", seen); end
    vec++; if (bus.instr_addr !== 32'h100) begin errs++; $display("FAIL full_head got %h want 100", bus.instr_addr); end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    vec++; if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 32'h104 || bus.instr_data !== 32'hFFFFFEFB) begin
      errs++; $display("FAIL pop_order got v=%b a=%h d=%h want 1/104/fffffefb", bus.instr_valid, bus.instr_addr, bus.instr_data); end
    while (!bus.mem_req && n < 10) begin @(negedge clk); n++; end
    vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h108) begin
      errs++; $display("FAIL refill_req got req=%b addr=%h want 1/108", bus.mem_req, bus.mem_addr); end
    repeat (4) @(negedge clk);
    vec++; if (step_cnt != 3 || pc_model !== 32'h10C) begin
      errs++; $display("FAIL refill_step got n=%0d pc=%h want 3/10c", step_cnt, pc_model); end
  endtask

  task automatic test_branch_idle();
    bus.branch_req = 1'b1;
    bus.branch_offset = 32'hFFFFFFF8;
    @(negedge clk);
    vec++; if (bus.pc_ctl !== 2'b01 || bus.pc_bus_out !== 32'hFFFFFFF8 || bus.step_pc !== 1'b0 || bus.instr_valid !== 1'b1) begin
      errs++; $display("FAIL br_setup got ctl=%b bus=%h step=%b v=%b want 01/fffffff8/0/1", bus.pc_ctl, bus.pc_bus_out, bus.step_pc, bus.instr_valid); end
    @(negedge clk);
    vec++; if (bus.pc_ctl !== 2'b01 || bus.pc_bus_out !== 32'hFFFFFFF8 || bus.step_pc !== 1'b1 || bus.branch_ack !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errs++; $display("FAIL br_pulse got ctl=%b bus=%h step=%b ack=%b v=%b want 01/fffffff8/1/1/0", bus.pc_ctl, bus.pc_bus_out, bus.step_pc, bus.branch_ack, bus.instr_valid); end
    bus.branch_req = 1'b0;
    @(negedge clk);
    vec++; if (bus.branch_ack !== 1'b0 || pc_model !== 32'h104 || last_ctl !== 2'b01 || step_cnt != 4) begin
      errs++; $display("FAIL br_done got ack=%b pc=%h ctl=%b n=%0d want 0/104/01/4", bus.branch_ack, pc_model, last_ctl, step_cnt); end
  endtask

  task automatic test_branch_in_req();
    int n = 0;
    int s0;
    bit pushed = 1'b0;
    bit req_in_br = 1'b0;
    bit got_ack = 1'b0;
    do_reset(32'h200);
    ack_delay = 3;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    vec++; if (bus.mem_req !== 1'b1) begin errs++; $display("FAIL brq_req_wait got req=%b want 1", bus.mem_req); end
    bus.branch_req = 1'b1;
    bus.branch_offset = 32'h40;
    s0 = step_cnt;
    n = 0;
    while (!got_ack && n < 20) begin
      @(negedge clk); n++;
      if (bus.instr_valid) pushed = 1'b1;
      if (bus.pc_ctl == 2'b01 && bus.mem_req) req_in_br = 1'b1;
      if (bus.branch_ack) got_ack = 1'b1;
    end
    bus.branch_req = 1'b0;
    vec++; if (got_ack !== 1'b1 || pushed !== 1'b0 || req_in_br !== 1'b0) begin
      errs++; $display("FAIL brq_flow got ack=%b push=%b req_in_br=%b want 1/0/0", got_ack, pushed, req_in_br); end
    @(negedge clk);
    vec++; if (step_cnt != s0 + 1 || last_ctl !== 2'b01 || pc_model !== 32'h240) begin
      errs++; $display("FAIL brq_step got n=%0d ctl=%b pc=%h want %0d/01/240", step_cnt, last_ctl, pc_model, s0 + 1); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset(32'h300);
    while (!bus.instr_valid && n < 20) begin @(negedge clk); n++; end
    vec++; if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 32'h300) begin
      errs++; $display("FAIL b2b_first got v=%b a=%h want 1/300", bus.instr_valid, bus.instr_addr); end
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    vec++; if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 32'h304 || bus.instr_data !== 32'hFFFFFCFB) begin
      errs++; $display("FAIL b2b_head got v=%b a=%h d=%h want 1/304/fffffcfb", bus.instr_valid, bus.instr_addr, bus.instr_data); end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    vec++; if (bus.instr_valid !== 1'b0) begin errs++; $display("FAIL b2b_count got v=%b want 0", bus.instr_valid); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int hi = 1;
    do_reset(32'h400);
    ack_en = 1'b0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    while (bus.mem_req && hi < 40) begin @(negedge clk); if (bus.mem_req) hi++; end
`ifdef FETCH_TIMEOUT_EN
    vec++; if (hi != 4 || bus.fetch_err !== 1'b1 || step_cnt != 0 || bus.instr_valid !== 1'b0) begin
      errs++; $display("FAIL to_drop got hi=%0d err=%b n=%0d v=%b want 4/1/0/0", hi, bus.fetch_err, step_cnt, bus.instr_valid); end
    ack_en = 1'b1;
    n = 0;
    while (!bus.instr_valid && n < 30) begin @(negedge clk); n++; end
    vec++; if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 32'h400 || bus.fetch_err !== 1'b1) begin
      errs++; $display("FAIL to_retry got v=%b a=%h err=%b want 1/400/1", bus.instr_valid, bus.instr_addr, bus.fetch_err); end
`else
    vec++; if (hi != 40 || bus.fetch_err !== 1'b0) begin
      errs++; $display("FAIL no_to got hi=%0d err=%b want 40/0", hi, bus.fetch_err); end
`endif
  endtask

  task automatic test_reset_mid_req();
    int n = 0;
    do_reset(32'h500);
    ack_en = 1'b0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500) begin
      errs++; $display("FAIL mid_req got req=%b a=%h want 1/500", bus.mem_req, bus.mem_addr); end
    rst = 1'b1;
    #1;
    vec++; if ({bus.pc_ctl, bus.step_pc, bus.mem_req, bus.branch_ack, bus.fetch_err, bus.instr_valid} !== 7'b0 || bus.mem_addr !== 32'h0 || bus.pc_bus_out !== 32'h0) begin
      errs++; $display("FAIL mid_rst got ctl=%b req=%b a=%h want all 0", bus.pc_ctl, bus.mem_req, bus.mem_addr); end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.branch_req = 1'b0;
    bus.branch_offset = '0;
    test_reset();
    test_fetch();
    test_queue_full();
    test_branch_idle();
    test_branch_in_req();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program counter's control side: commands the PC onto the system bus, captures the fetch address, and reads the instruction word from memory.
- Buffers fetched words for the decoder in a small in-order queue.
- Generates the PC's step_pc strobe and ctl lines: increment after every fetch, or add a branch offset on decoder request.
- Sits between the PC, instruction memory and the decode stage.

Parameters:
- DEPTH, 2, instruction queue entries (power of two, >=2).
- TIMEOUT_CYCLES, 255, mem_ack wait limit; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- pc_bus_in  input  32  PC value from the PC's system bus output
- pc_bus_out  output  32  offset driven to the PC's system bus input
- pc_ctl  output  2  to the PC: [1]=drive PC onto bus; [0]=0 increment by 4, 1 add bus
- step_pc  output  1  PC update strobe; the PC acts on its rising edge
- mem_req  output  1  memory read request
- mem_addr  output  32  read address
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  one-cycle read completion
- instr_valid  output  1  queue head valid
- instr_ready  input  1  decoder accepts head
- instr_data  output  32  head instruction word
- instr_addr  output  32  head fetch address
- branch_req  input  1  held high by the decoder until branch_ack
- branch_offset  input  32  signed offset, stable while branch_req is high
- branch_ack  output  1  one-cycle branch completion
- fetch_err  output  1  sticky timeout flag; only with the optional feature

Behaviour:
- Reset (async): state IDLE; pc_ctl=2'b00; step_pc=0; mem_req=0; mem_addr=0; pc_bus_out=0; branch_ack=0; fetch_err=0; queue empty; instr_valid=0.
- All outputs are registered. step_pc is glitch-free.
- States and transitions:
  - IDLE: if branch_req -> BR_SETUP; else if queue not full -> ADDR; else stay.
  - ADDR: pc_ctl[1]=1 for one cycle; latch pc_bus_in into mem_addr at the cycle end -> REQ.
  - REQ: mem_req=1 and mem_addr held until mem_ack.
    - On mem_ack with no branch_req: push {mem_addr, mem_rdata}; mem_req falls the next cycle -> ST_SETUP.
    - On mem_ack with branch_req high: discard the data; no push -> BR_SETUP.
  - ST_SETUP: pc_ctl=2'b00; step_pc=0 -> ST_PULSE.
  - ST_PULSE: pc_ctl=2'b00; step_pc=1 -> IDLE. The PC advances by 4.
  - BR_SETUP: pc_bus_out=branch_offset; pc_ctl=2'b01; step_pc=0; flush the queue (instr_valid=0 the next cycle) -> BR_PULSE.
  - BR_PULSE: same drives as BR_SETUP; step_pc=1; branch_ack=1 -> IDLE.
- ctl and bus values are stable one full cycle before the step_pc rising edge and through the pulse.
- Branch semantics:
  - The offset is added to the PC as it stands at BR_PULSE.
  - A branch is never started while mem_req is high.
  - branch_req arriving in ADDR: ADDR and REQ complete first; the fetched data is discarded.
- Fetch latency: 5 cycles minimum from IDLE to the step_pc pulse with mem_ack on the first REQ cycle. The pushed word is visible on instr_valid 1 cycle after mem_ack.
- Queue:
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Full: no new ADDR is issued. Empty: instr_valid=0.
  - Pointers wrap modulo DEPTH. A flush overrides a same-cycle pop or push.
- Address arithmetic is 32-bit modulo. Fetch addresses are not alignment-checked.
- mem_ack outside REQ is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With it defined:
  - A counter runs in REQ.
  - If TIMEOUT_CYCLES elapse with no mem_ack: drop mem_req, set fetch_err (sticky until rst), go to IDLE. No push and no step.
  - Retry proceeds normally afterwards.
- Without it: REQ waits indefinitely; fetch_err is tied to 0.

Test Plan:
- Reset then PC=0x00000100, mem_ack 1 cycle after mem_req, rdata=0xDEADBEEF -> mem_addr=0x100; one step_pc with pc_ctl=00; instr_valid with data 0xDEADBEEF, addr 0x100.
- instr_ready=0, PC increments 0x100/0x104 -> two entries queued; no third mem_req until one pop; pop order 0x100 then 0x104.
- branch_req with offset 0xFFFFFFF8 in IDLE, queue holding 2 entries -> pc_bus_out=0xFFFFFFF8 and pc_ctl=01 for 2 cycles; step_pc in the 2nd cycle; branch_ack=1; instr_valid=0.
- branch_req raised during REQ, mem_ack 3 cycles later -> no push, no increment step; exactly one step_pc with pc_ctl=01.
- Simultaneous pop and push with queue at 1 entry -> count stays 1; head is the new word.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_ack -> mem_req drops after 4 cycles; fetch_err=1; no step_pc; assert rst mid-REQ -> all outputs return to their reset values immediately.
